// File: rtl/and_or_reg_arbiter.sv
// Round-robin sequencer that shares one AND-OR + output-register datapath among
// NUM_REQ requesters and returns the registered result tagged with the winner's index.
module and_or_reg_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   opnd,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   busy,
  output logic                   dp_a,
  output logic                   dp_b,
  output logic                   dp_c,
  output logic                   dp_d,
  input  logic                   dp_f,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   rsp_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cur_id;

  logic            found_c;
  logic [ID_W-1:0] win_c;
  logic [ID_W-1:0] nxt_ptr_c;
  logic [3:0]      win_opnd_c;

  // Rotating priority scan starting at rr_ptr; first set request wins.
  always_comb begin
    int unsigned idx;
    int unsigned wn;
    found_c    = 1'b0;
    win_c      = '0;
    idx        = 0;
    wn         = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found_c && req[ID_W'(idx)]) begin
        found_c = 1'b1;
        win_c   = ID_W'(idx);
      end
    end
    wn         = 32'(win_c) + 32'd1;
    nxt_ptr_c  = (wn >= NUM_REQ) ? '0 : ID_W'(wn);
    win_opnd_c = opnd[4*32'(win_c) +: 4];
  end

  // Sequencer: IDLE picks and launches, EXEC lets the datapath register load, CAPT returns f.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      dp_a      <= 1'b0;
      dp_b      <= 1'b0;
      dp_c      <= 1'b0;
      dp_d      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (found_c) begin
            {dp_a, dp_b, dp_c, dp_d} <= win_opnd_c;
            cur_id <= win_c;
            gnt    <= NUM_REQ'(1) << win_c;
            rr_ptr <= nxt_ptr_c;
            busy   <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          gnt   <= '0;
          state <= CAPT;
        end
        CAPT: begin
          rsp_data  <= dp_f;
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_and_or_reg_arbiter.sv
// Scoreboard bench for and_or_reg_arbiter: queued requesters drive stimulus, a monitor
// checks grants and responses against hand-computed expectations.
module tb_and_or_reg_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] opnd;
  logic [NUM_REQ-1:0]   gnt;
  logic                 busy;
  logic                 dp_a, dp_b, dp_c, dp_d;
  logic                 dp_f;
  logic                 rsp_valid;
  logic [ID_W-1:0]      rsp_id;
  logic                 rsp_data;

  and_or_reg_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst(rst), .req(req), .opnd(opnd), .gnt(gnt), .busy(busy),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d), .dp_f(dp_f),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  // Shared AND-OR + output register unit
  always @(posedge clk) dp_f <= (dp_a & dp_b) | (dp_c & dp_d);

  typedef struct { logic [3:0] gnt; logic [3:0] dp; int gap; } gexp_t;
  typedef struct { logic [ID_W-1:0] id; logic data; } rexp_t;

  gexp_t      gq[$];
  rexp_t      rq[$];
  int         gcyc_q[$];
  logic [3:0] opq [4][$];

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int rsp_seen = 0;
  int last_gcyc = -100;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  task automatic fail_note(input string nm);
    total++;
    $display("FAIL %s", nm);
  endtask

  task automatic push_op(input int i, input logic [3:0] nib, input logic data, input int gap);
    opq[i].push_back(nib);
    gq.push_back('{gnt: 4'(1 << i), dp: nib, gap: gap});
    rq.push_back('{id: ID_W'(i), data: data});
  endtask

  task automatic wait_done(input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      if (gq.size() == 0 && rq.size() == 0 && !busy &&
          opq[0].size() == 0 && opq[1].size() == 0 &&
          opq[2].size() == 0 && opq[3].size() == 0) done = 1'b1;
    end
    if (!done) fail_note("timeout waiting for ops to drain");
    @(negedge clk);
  endtask

  // Requesters: hold req/opnd until granted, then advance to the next queued op.
  initial begin
    req  = '0;
    opnd = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (gnt[i] && opq[i].size() > 0) void'(opq[i].pop_front());
        req[i] = (opq[i].size() != 0);
        opnd[4*i +: 4] = req[i] ? opq[i][0] : 4'b0000;
      end
    end
  end

  // Monitor: pop expectations whenever the DUT presents a grant or a response.
  initial begin
    gexp_t ge;
    rexp_t re;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) gcyc_q.delete();
      else begin
        if (gnt != '0) begin
          if (gq.size() == 0) fail_note("unexpected gnt");
          else begin
            ge = gq.pop_front();
            chk("gnt", 32'(gnt), 32'(ge.gnt));
            chk("dp_abcd", 32'({dp_a, dp_b, dp_c, dp_d}), 32'(ge.dp));
            chk("busy_exec", 32'(busy), 32'd1);
            if (ge.gap > 0) chk("gnt_spacing", 32'(cyc - last_gcyc), 32'(ge.gap));
          end
          last_gcyc = cyc;
          gcyc_q.push_back(cyc);
        end
        if (rsp_valid) begin
          rsp_seen++;
          if (rq.size() == 0) fail_note("unexpected rsp_valid");
          else begin
            re = rq.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(re.id));
            chk("rsp_data", 32'(rsp_data), 32'(re.data));
          end
          if (gcyc_q.size() == 0) fail_note("rsp without grant");
          else chk("rsp_latency", 32'(cyc - gcyc_q.pop_front()), 32'd2);
        end
      end
    end
  end

  initial begin
    int seen0;
    bit got;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dp", 32'({dp_a, dp_b, dp_c, dp_d}), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single request, a&b=1
    @(posedge clk); #1;
    push_op(0, 4'b1100, 1'b1, 0);
    @(negedge clk);
    @(negedge clk);
    chk("first_gnt_latency", 32'(gnt), 32'h1);
    wait_done(50);

    // Back-to-back ops from one requester: 1010 -> 0, 0011 -> 1
    @(posedge clk); #1;
    push_op(0, 4'b1010, 1'b0, 0);
    push_op(0, 4'b0011, 1'b1, 3);
    wait_done(50);

    // Reset in the middle of EXEC discards the op
    @(posedge clk); #1;
    opq[2].push_back(4'b1111);
    gq.push_back('{gnt: 4'b0100, dp: 4'b1111, gap: 0});
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (gnt[2]) got = 1'b1;
    end
    if (!got) fail_note("timeout waiting for gnt[2]");
    #1 rst = 1'b1;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_dp", 32'({dp_a, dp_b, dp_c, dp_d}), 32'd0);
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen0 = rsp_seen;
    repeat (6) @(negedge clk);
    chk("no_rsp_after_reset", 32'(rsp_seen - seen0), 32'd0);

    // All four requesting from rr_ptr=0: order 0,1,2,3,0, one grant every 3 cycles
    @(posedge clk); #1;
    push_op(0, 4'b1100, 1'b1, 0);
    push_op(1, 4'b0011, 1'b1, 3);
    push_op(2, 4'b1000, 1'b0, 3);
    push_op(3, 4'b0110, 1'b0, 3);
    push_op(0, 4'b1111, 1'b1, 3);
    wait_done(100);

    // Request from 0 arrives while 3 is busy; opnd[15:12] drops to 0 during EXEC
    @(posedge clk); #1;
    push_op(3, 4'b1100, 1'b1, 0);
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (gnt[3]) got = 1'b1;
    end
    if (!got) fail_note("timeout waiting for gnt[3]");
    #1;
    push_op(0, 4'b0011, 1'b1, 3);
    wait_done(50);

    // Grant to 2 leaves rr_ptr=3; then 0 and 2 together -> 0 wins (wrap), then 2
    @(posedge clk); #1;
    push_op(2, 4'b1111, 1'b1, 0);
    wait_done(50);
    @(posedge clk); #1;
    push_op(0, 4'b1000, 1'b0, 0);
    push_op(2, 4'b0011, 1'b1, 3);
    wait_done(50);

    chk("grant_queue_drained", 32'(gq.size()), 32'd0);
    chk("rsp_queue_drained", 32'(rq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
